fwd_int_tx4x4: RTL
==================

// Module: fwd_int_tx4x4
// PURPOSE
//   H.264 4x4 forward integer core transform, Y = Cf*X*Cf^T, with
//   Cf = [1 1 1 1; 2 1 -1 -2; 1 -1 -1 1; 1 -2 2 -1].
//   Sits directly downstream of the motion-compensation residual stage and
//   consumes its 4x4 residual block. Feeds the quantiser.
//   Sequential: one row per cycle (row pass), then one column per cycle
//   (column pass). Valid/ready handshake on both sides.
//   Scaling and quantisation are out of scope.
// PARAMETERS
//   MB_SIZE    4      block dimension. Only 4 is supported.
//   RES_WIDTH  9      signed residual width (range -255..255 when 9).
//   OUT_WIDTH  RES_WIDTH+6  signed coefficient width (max gain 6*6 = 36).
// PORTS
//   clk        in   1                  single clock, rising edge
//   reset_n    in   1                  asynchronous, active-low reset
//   residual   in   RES_WIDTH [4][4]   signed residual block; sampled on accept
//   src_valid  in   1                  upstream block valid
//   src_ready  out  1                  block can be accepted this cycle
//   coeff      out  OUT_WIDTH [4][4]   signed transform coefficients
//   dst_valid  out  1                  coeff holds a finished block
//   dst_ready  in   1                  downstream takes coeff
// BEHAVIOUR
// - Reset (reset_n=0, asynchronous): state=IDLE, coeff=0, all internal
//   X/W registers=0, dst_valid=0, src_ready=0, row/col counter=0.
// - src_ready is 0 until the first clk edge after reset_n rises. After that,
//   src_ready = (state==IDLE).
// - FSM states: IDLE -> ROW -> COL -> DONE -> IDLE.
//   - IDLE: on src_valid&&src_ready, capture residual into X and go to ROW
//     with cnt=0. This edge is the "accept edge". Otherwise stay in IDLE.
//   - ROW: each edge writes W[cnt][*] from butterfly(X[cnt][*]) and
//     increments cnt. When cnt=3, go to COL with cnt=0.
//   - COL: each edge writes coeff[*][cnt] from butterfly(W[*][cnt]) and
//     increments cnt. When cnt=3, go to DONE and set dst_valid=1.
//   - DONE: dst_valid=1. coeff is held bit-stable. On dst_ready, clear
//     dst_valid and go to IDLE. There is no same-cycle re-accept.
// - Latency: dst_valid rises at the 8th edge after the accept edge.
//   Minimum block period is 10 cycles (accept, 8 compute, 1 handoff).
// - Butterfly on inputs a0..a3:
//   - s0=a0+a3, s1=a1+a2, d0=a0-a3, d1=a1-a2.
//   - outputs: o0=s0+s1, o1=(d0<<<1)+d1, o2=s0-s1, o3=d0-(d1<<<1).
// - Widths and arithmetic:
//   - All arithmetic is signed two's complement.
//   - W is RES_WIDTH+3 bits. Row gain is at most 6, so no overflow.
//   - Column-pass results are RES_WIDTH+6 bits and are exact. There is no
//     saturation and no wrap for any in-range input.
// - src_valid/residual are ignored outside IDLE. Upstream holds the block
//   until accepted.
// - dst_ready is ignored outside DONE.
// - coeff changes only during COL, and at reset.
// - Reset mid-operation (any state) aborts the block. The block is not
//   emitted, and outputs return to their reset values immediately.
// TESTING
// 1. All-zero block, dst_ready=1 -> coeff all 0. dst_valid high exactly
//    8 edges after accept, for 1 cycle.
// 2. X all +1 -> coeff[0][0]=16, all others 0. X all -255 ->
//    coeff[0][0]=-4080, all others 0.
// 3. Impulse X[0][0]=1, else 0 -> coeff[i][j]=c[i]*c[j] with c={1,2,1,1}.
//    Check coeff[1][1]=4, coeff[0][1]=2, coeff[3][3]=1.
// 4. Worst-case gain: X[i][j]=255*sgn(Cf[1][i]*Cf[1][j]) -> coeff[1][1]=9180.
//    No overflow at OUT_WIDTH=15.
// 5. Backpressure: hold dst_ready=0 for 20 cycles in DONE -> coeff stable,
//    src_ready=0, and a src_valid pulse with new data is ignored. Release ->
//    one handoff, then src_ready=1 on the next cycle.
// 6. Assert reset_n=0 at the 2nd ROW edge -> dst_valid=0, coeff=0,
//    src_ready=0. After release, a fresh all-ones block -> coeff[0][0]=16
//    with no residue from the aborted block.

Source files
------------

// File: rtl/fwd_int_tx4x4.sv
// fwd_int_tx4x4 -- H.264 4x4 forward integer core transform, Y = Cf*X*Cf^T,
// with Cf = [1 1 1 1; 2 1 -1 -2; 1 -1 -1 1; 1 -2 2 -1].
// The transform runs sequentially. A row pass processes one row of X per
// cycle into the intermediate W. A column pass then processes one column of W
// per cycle into coeff.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. Upstream holds residual stable while src_valid=1
// until it is accepted. coeff stays bit-stable while dst_valid=1 until the
// edge on which dst_ready=1.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   residual     in   signed RES_WIDTH residual block [row][col]
//   src_valid    in   upstream block valid
//   src_ready    out  block accepted this cycle if src_valid
//   coeff        out  signed OUT_WIDTH coefficients [row][col]
//   dst_valid    out  coeff holds a finished block
//   dst_ready    in   downstream takes coeff
//   o_dbg_state  out  FSM state (0 IDLE, 1 ROW, 2 COL, 3 DONE)
module fwd_int_tx4x4 #(
  parameter int MB_SIZE   = 4,
  parameter int RES_WIDTH = 9,
  parameter int OUT_WIDTH = RES_WIDTH + 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [RES_WIDTH-1:0] residual [MB_SIZE][MB_SIZE],
  input  logic                        src_valid,
  output logic                        src_ready,
  output logic signed [OUT_WIDTH-1:0] coeff [MB_SIZE][MB_SIZE],
  output logic                        dst_valid,
  input  logic                        dst_ready,
  output logic [1:0]                  o_dbg_state
);

  // The row gain is at most 6, so 3 extra bits hold W exactly.
  localparam int W_WIDTH = RES_WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_COL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      r_state;
  logic [1:0]                  r_cnt;
  logic                        r_src_ready;
  logic                        r_dst_valid;
  logic signed [RES_WIDTH-1:0] r_x     [MB_SIZE][MB_SIZE];
  logic signed [W_WIDTH-1:0]   r_w     [MB_SIZE][MB_SIZE];
  logic signed [OUT_WIDTH-1:0] r_coeff [MB_SIZE][MB_SIZE];

  logic signed [W_WIDTH-1:0]   w_row_in  [MB_SIZE];
  logic signed [OUT_WIDTH-1:0] w_col_in  [MB_SIZE];
  logic [MB_SIZE*W_WIDTH-1:0]  w_row_out;
  logic [MB_SIZE*OUT_WIDTH-1:0] w_col_out;

  // Butterfly for the row pass. Lanes are packed {o3, o2, o1, o0}.
  function automatic logic [4*W_WIDTH-1:0] bfly_row(
    input logic signed [W_WIDTH-1:0] a0, a1, a2, a3
  );
    logic signed [W_WIDTH-1:0] s0, s1, d0, d1;
    s0 = a0 + a3;
    s1 = a1 + a2;
    d0 = a0 - a3;
    d1 = a1 - a2;
    return {d0 - (d1 <<< 1), s0 - s1, (d0 <<< 1) + d1, s0 + s1};
  endfunction

  // Same butterfly at column-pass width. Lanes are packed {o3, o2, o1, o0}.
  function automatic logic [4*OUT_WIDTH-1:0] bfly_col(
    input logic signed [OUT_WIDTH-1:0] a0, a1, a2, a3
  );
    logic signed [OUT_WIDTH-1:0] s0, s1, d0, d1;
    s0 = a0 + a3;
    s1 = a1 + a2;
    d0 = a0 - a3;
    d1 = a1 - a2;
    return {d0 - (d1 <<< 1), s0 - s1, (d0 <<< 1) + d1, s0 + s1};
  endfunction

  // The row pass reads X row r_cnt. The column pass reads W column r_cnt.
  // Each input is sign-extended to the width of its pass.
  always_comb begin
    for (int k = 0; k < MB_SIZE; k++) begin
      w_row_in[k] = {{(W_WIDTH-RES_WIDTH){r_x[r_cnt][k][RES_WIDTH-1]}},
                     r_x[r_cnt][k]};
      w_col_in[k] = {{(OUT_WIDTH-W_WIDTH){r_w[k][r_cnt][W_WIDTH-1]}},
                     r_w[k][r_cnt]};
    end
    w_row_out = bfly_row(w_row_in[0], w_row_in[1], w_row_in[2], w_row_in[3]);
    w_col_out = bfly_col(w_col_in[0], w_col_in[1], w_col_in[2], w_col_in[3]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_src_ready <= 1'b0;
      r_dst_valid <= 1'b0;
      for (int i = 0; i < MB_SIZE; i++) begin
        for (int j = 0; j < MB_SIZE; j++) begin
          r_x[i][j]     <= '0;
          r_w[i][j]     <= '0;
          r_coeff[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // src_ready goes high on the first edge after reset and
          // stays high while the FSM waits in IDLE.
          r_src_ready <= 1'b1;
          if (src_valid && r_src_ready) begin
            r_x         <= residual;
            r_cnt       <= 2'd0;
            r_src_ready <= 1'b0;
            r_state     <= S_ROW;
          end
        end
        S_ROW: begin
          for (int j = 0; j < MB_SIZE; j++) begin
            r_w[r_cnt][j] <= w_row_out[j*W_WIDTH +: W_WIDTH];
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= S_COL;
          end
        end
        S_COL: begin
          for (int j = 0; j < MB_SIZE; j++) begin
            r_coeff[j][r_cnt] <= w_col_out[j*OUT_WIDTH +: OUT_WIDTH];
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_dst_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // src_ready rises with the handoff, so a new block can be
          // accepted no earlier than the following edge.
          if (dst_ready) begin
            r_dst_valid <= 1'b0;
            r_src_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign src_ready   = r_src_ready;
  assign dst_valid   = r_dst_valid;
  assign coeff       = r_coeff;
  assign o_dbg_state = r_state;

endmodule
